// File: rtl/if_stage_pkg.sv
// Shared widths and FSM encoding for the MIPS instruction-fetch stage.
// The optional performance counters are enabled with the FS_PERF_CNT_EN macro.
package if_stage_pkg;

    localparam int unsigned FS_TO_DS_BUS_WD = 64;
    localparam int unsigned JUMP_BUS_WD     = 33;

    typedef enum logic [1:0] {
        StReq   = 2'd0,
        StWait  = 2'd1,
        StValid = 2'd2
    } fs_state_e;

    function automatic logic [31:0] seq_pc(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/if_stage.sv
// Instruction-fetch stage: one outstanding req/addr_ok/data_ok fetch, delay-slot jump handling.
// Define FS_PERF_CNT_EN to add the fs_fetch_cnt / fs_stall_cnt performance counters.
module if_stage
    import if_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       ds_allowin,
    input  logic [JUMP_BUS_WD-1:0]     jump_bus,
    output logic                       fs_to_ds_valid,
    output logic [FS_TO_DS_BUS_WD-1:0] fs_to_ds_bus,
    output logic                       inst_req,
    output logic [31:0]                inst_addr,
    input  logic                       inst_addr_ok,
    input  logic                       inst_data_ok,
`ifdef FS_PERF_CNT_EN
    output logic [31:0]                fs_fetch_cnt,
    output logic [31:0]                fs_stall_cnt,
`endif
    input  logic [31:0]                inst_rdata
);

    fs_state_e   state_q;
    logic        req_q;
    logic        valid_q;
    logic        br_pending_q;
    logic [31:0] br_target_q;
    logic [31:0] addr_q;
    logic [31:0] fs_pc_q;
    logic [31:0] instr_q;

    logic        jump_taken;
    logic [31:0] jump_target;
    logic [31:0] next_pc;

    assign jump_taken  = jump_bus[32];
    assign jump_target = jump_bus[31:0];

    // A pending target is only consumed when the delay slot leaves IF.
    always_comb begin
        next_pc = seq_pc(fs_pc_q);
        if (br_pending_q) begin
            next_pc = br_target_q;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= StReq;
            req_q        <= 1'b0;
            valid_q      <= 1'b0;
            br_pending_q <= 1'b0;
            br_target_q  <= 32'd0;
            addr_q       <= RESET_PC;
            fs_pc_q      <= 32'd0;
            instr_q      <= 32'd0;
        end else begin
            if (jump_taken && !br_pending_q) begin
                br_pending_q <= 1'b1;
                br_target_q  <= jump_target;
            end
            unique case (state_q)
                StReq: begin
                    // req_q is low for the first cycle after reset; addr_ok only counts while requesting.
                    if (req_q && inst_addr_ok) begin
                        fs_pc_q <= addr_q;
                        req_q   <= 1'b0;
                        state_q <= StWait;
                    end else begin
                        req_q <= 1'b1;
                    end
                end
                StWait: begin
                    if (inst_data_ok) begin
                        instr_q <= inst_rdata;
                        valid_q <= 1'b1;
                        state_q <= StValid;
                    end
                end
                StValid: begin
                    if (ds_allowin) begin
                        valid_q <= 1'b0;
                        addr_q  <= next_pc;
                        req_q   <= 1'b1;
                        state_q <= StReq;
                        if (br_pending_q) begin
                            br_pending_q <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_q <= StReq;
                    req_q   <= 1'b0;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign fs_to_ds_valid = valid_q;
    assign fs_to_ds_bus   = {instr_q, fs_pc_q};
    assign inst_req       = req_q;
    assign inst_addr      = addr_q;

`ifdef FS_PERF_CNT_EN
    logic [31:0] fetch_cnt_q;
    logic [31:0] stall_cnt_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_cnt_q <= 32'd0;
            stall_cnt_q <= 32'd0;
        end else if (valid_q) begin
            if (ds_allowin) begin
                fetch_cnt_q <= fetch_cnt_q + 32'd1;
            end else begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
        end
    end

    assign fs_fetch_cnt = fetch_cnt_q;
    assign fs_stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: memory responder, transaction-level flow model, directed tests.
module tb_if_stage;

    localparam logic [31:0] RESET_PC = 32'hBFC0_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ds_allowin;
    logic [32:0] jump_bus;
    logic        fs_to_ds_valid;
    logic [63:0] fs_to_ds_bus;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;
`ifdef FS_PERF_CNT_EN
    logic [31:0] fs_fetch_cnt;
    logic [31:0] fs_stall_cnt;
`endif

    if_stage #(.RESET_PC(RESET_PC)) dut (
        .clk           (clk),
        .reset         (rst_n),
        .ds_allowin    (ds_allowin),
        .jump_bus      (jump_bus),
        .fs_to_ds_valid(fs_to_ds_valid),
        .fs_to_ds_bus  (fs_to_ds_bus),
        .inst_req      (inst_req),
        .inst_addr     (inst_addr),
        .inst_addr_ok  (inst_addr_ok),
        .inst_data_ok  (inst_data_ok),
`ifdef FS_PERF_CNT_EN
        .fs_fetch_cnt  (fs_fetch_cnt),
        .fs_stall_cnt  (fs_stall_cnt),
`endif
        .inst_rdata    (inst_rdata)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    logic [31:0] req_log[$];
    int          hs_cyc[$];

    task automatic check(input bit ok, input string nm, input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] memf(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Instruction memory: addr_ok after addr_lat waiting cycles, data data_lat cycles later.
    int          addr_lat = 0;
    int          data_lat = 0;
    bit          busy = 0;
    int          acnt = 0;
    int          dcnt = 0;
    logic [31:0] lat_addr = '0;

    initial begin
        inst_addr_ok = 1'b0;
        inst_data_ok = 1'b0;
        inst_rdata   = 32'hDEAD_BEEF;
        forever begin
            @(posedge clk);
            #1;
            inst_addr_ok = 1'b0;
            inst_data_ok = 1'b0;
            inst_rdata   = 32'hDEAD_BEEF;
            if (!rst_n) begin
                busy = 0;
                acnt = 0;
            end else if (busy) begin
                if (dcnt == 0) begin
                    inst_data_ok = 1'b1;
                    inst_rdata   = memf(lat_addr);
                    busy         = 0;
                end else begin
                    dcnt--;
                end
            end else if (inst_req) begin
                if (acnt >= addr_lat) begin
                    inst_addr_ok = 1'b1;
                    busy         = 1;
                    dcnt         = data_lat;
                    lat_addr     = inst_addr;
                    acnt         = 0;
                end else begin
                    acnt++;
                end
            end
        end
    end

    // Program-flow model: next fetch is pc+4, or the jump target once the delay slot is handed over.
    logic [31:0] m_exp_addr;
    logic [31:0] m_cur_pc;
    logic [31:0] m_tgt;
    bit          m_pend;
    logic [31:0] m_fetch;
    logic [31:0] m_stall;
    bit          st_flag;
    logic [63:0] st_bus;
    bit          rq_flag;
    logic [31:0] rq_addr;

    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            m_exp_addr = RESET_PC;
            m_cur_pc   = '0;
            m_tgt      = '0;
            m_pend     = 0;
            m_fetch    = '0;
            m_stall    = '0;
            st_flag    = 0;
            rq_flag    = 0;
        end else begin
`ifdef FS_PERF_CNT_EN
            check(fs_fetch_cnt == m_fetch, "fetch_cnt", fs_fetch_cnt, m_fetch);
            check(fs_stall_cnt == m_stall, "stall_cnt", fs_stall_cnt, m_stall);
`endif
            if (rq_flag) begin
                check(inst_req == 1'b1, "req_held", inst_req, 1);
                check(inst_addr == rq_addr, "addr_stable", inst_addr, rq_addr);
            end
            rq_flag = 0;
            if (inst_req) begin
                if (inst_addr_ok) begin
                    check(inst_addr == m_exp_addr, "req_addr", inst_addr, m_exp_addr);
                    req_log.push_back(inst_addr);
                    m_cur_pc = inst_addr;
                end else begin
                    rq_flag = 1;
                    rq_addr = inst_addr;
                end
            end
            if (st_flag) begin
                check(fs_to_ds_valid == 1'b1, "valid_held", fs_to_ds_valid, 1);
                check(fs_to_ds_bus == st_bus, "bus_held", fs_to_ds_bus, st_bus);
            end
            st_flag = 0;
            if (fs_to_ds_valid) begin
                check(fs_to_ds_bus == {memf(m_cur_pc), m_cur_pc}, "bus", fs_to_ds_bus,
                      {memf(m_cur_pc), m_cur_pc});
                check(inst_req == 1'b0, "no_req_in_valid", inst_req, 0);
                if (ds_allowin) begin
                    hs_cyc.push_back(cyc);
                    m_fetch    = m_fetch + 32'd1;
                    m_exp_addr = m_pend ? m_tgt : m_cur_pc + 32'd4;
                    m_pend     = 0;
                end else begin
                    m_stall = m_stall + 32'd1;
                    st_flag = 1;
                    st_bus  = fs_to_ds_bus;
                end
            end
            if (jump_bus[32] && !m_pend) begin
                m_pend = 1;
                m_tgt  = jump_bus[31:0];
            end
        end
    end

    // Wait (bounded) for valid, then hand one instruction to decode.
    task automatic hs(output logic [31:0] pc);
        int n = 0;
        while (!fs_to_ds_valid && n < 60) begin
            @(posedge clk);
            #1;
            n++;
        end
        check(fs_to_ds_valid == 1'b1, "hs_timeout", fs_to_ds_valid, 1);
        pc = fs_to_ds_bus[31:0];
        ds_allowin = 1'b1;
        @(posedge clk);
        #1;
        ds_allowin = 1'b0;
    endtask

    initial begin
        logic [31:0] pc;
        logic [63:0] bus0;
        int          n0;
        int          n;

        rst_n      = 1'b0;
        ds_allowin = 1'b0;
        jump_bus   = '0;
        repeat (3) @(posedge clk);
        #1;
        check(fs_to_ds_valid == 1'b0, "rst_valid", fs_to_ds_valid, 0);
        check(inst_req == 1'b0, "rst_req", inst_req, 0);
        check(fs_to_ds_bus == 64'd0, "rst_bus", fs_to_ds_bus, 0);
        check(inst_addr == 32'hBFC0_0000, "rst_addr", inst_addr, 32'hBFC0_0000);

        // 1: free-running fetch, single-cycle memory
        ds_allowin = 1'b1;
        rst_n      = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        ds_allowin = 1'b0;
        check(req_log.size() >= 3, "t1_nreq", req_log.size(), 3);
        if (req_log.size() >= 3) begin
            check(req_log[0] == 32'hBFC0_0000, "t1_req0", req_log[0], 32'hBFC0_0000);
            check(req_log[1] == 32'hBFC0_0004, "t1_req1", req_log[1], 32'hBFC0_0004);
            check(req_log[2] == 32'hBFC0_0008, "t1_req2", req_log[2], 32'hBFC0_0008);
        end
        check(hs_cyc.size() >= 3, "t1_nhs", hs_cyc.size(), 3);
        if (hs_cyc.size() >= 3) begin
            check(hs_cyc[1] - hs_cyc[0] == 3, "t1_period0", hs_cyc[1] - hs_cyc[0], 3);
            check(hs_cyc[2] - hs_cyc[1] == 3, "t1_period1", hs_cyc[2] - hs_cyc[1], 3);
        end

        // 2: decode stalls for five cycles
        n = 0;
        while (!fs_to_ds_valid && n < 60) begin
            @(posedge clk);
            #1;
            n++;
        end
        bus0 = fs_to_ds_bus;
        n0   = req_log.size();
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check(fs_to_ds_bus == bus0, "t2_bus", fs_to_ds_bus, bus0);
            check(inst_req == 1'b0, "t2_req", inst_req, 0);
        end
        check(req_log.size() == n0, "t2_noreq", req_log.size(), n0);

        // 3: branch at BFC00010 to BFC00100
        for (int i = 0; i < 8; i++) begin
            hs(pc);
            if (pc == 32'hBFC0_0010) break;
        end
        check(pc == 32'hBFC0_0010, "t3_branch", pc, 32'hBFC0_0010);
        jump_bus = {1'b1, 32'hBFC0_0100};
        @(posedge clk);
        #1;
        jump_bus = '0;
        hs(pc);
        check(pc == 32'hBFC0_0014, "t3_slot", pc, 32'hBFC0_0014);
        hs(pc);
        check(pc == 32'hBFC0_0100, "t3_target", pc, 32'hBFC0_0100);
        hs(pc);
        check(pc == 32'hBFC0_0104, "t3_tgt4", pc, 32'hBFC0_0104);

        // 4: branch at BFC00104, jump held four cycles while decode stalls
        jump_bus = {1'b1, 32'hBFC0_0100};
        repeat (4) @(posedge clk);
        #1;
        jump_bus = '0;
        hs(pc);
        check(pc == 32'hBFC0_0108, "t4_slot", pc, 32'hBFC0_0108);
        hs(pc);
        check(pc == 32'hBFC0_0100, "t4_target", pc, 32'hBFC0_0100);
        hs(pc);
        check(pc == 32'hBFC0_0104, "t4_norepeat", pc, 32'hBFC0_0104);

        // 5: reset pulse while waiting for data
        data_lat = 2;
        hs(pc);
        @(posedge clk);
        #1;
        check(inst_req == 1'b0 && fs_to_ds_valid == 1'b0, "t5_in_wait",
              {inst_req, fs_to_ds_valid}, 0);
        #2;
        rst_n = 1'b0;
        #1;
        check(fs_to_ds_valid == 1'b0, "t5_valid", fs_to_ds_valid, 0);
        check(inst_req == 1'b0, "t5_req", inst_req, 0);
        check(inst_addr == RESET_PC, "t5_addr", inst_addr, RESET_PC);
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
        n0 = req_log.size();
        n  = 0;
        while (req_log.size() == n0 && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        check(req_log.size() > n0, "t5_reqseen", req_log.size(), n0 + 1);
        if (req_log.size() > n0) begin
            check(req_log[n0] == 32'hBFC0_0000, "t5_first", req_log[n0], 32'hBFC0_0000);
        end

        // 6: jump to FFFFFFFC, then sequential fetch wraps to 0
        addr_lat = 1;
        data_lat = 1;
        hs(pc);
        check(pc == 32'hBFC0_0000, "t6_branch", pc, 32'hBFC0_0000);
        jump_bus = {1'b1, 32'hFFFF_FFFC};
        @(posedge clk);
        #1;
        jump_bus = '0;
        hs(pc);
        check(pc == 32'hBFC0_0004, "t6_slot", pc, 32'hBFC0_0004);
        hs(pc);
        check(pc == 32'hFFFF_FFFC, "t6_top", pc, 32'hFFFF_FFFC);
        hs(pc);
        check(pc == 32'h0000_0000, "t6_wrap", pc, 32'h0000_0000);
        repeat (8) @(posedge clk);
        #1;
        hs(pc);
        check(pc == 32'h0000_0004, "t6_after_wrap", pc, 32'h0000_0004);
`ifdef FS_PERF_CNT_EN
        // Since the t5 reset: handshakes 0000_0000..., i.e. BFC00000, BFC00004, FFFFFFFC, 0, 4.
        check(fs_fetch_cnt == 32'd5, "t6_fetch_lit", fs_fetch_cnt, 5);
`endif
        repeat (3) @(posedge clk);
        #1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
